// File: rtl/keyscan_pkg.sv
// Shared definitions for the MEGA65 -> ZX-Uno key scan serializer.
//   KEY_IDX_W     width of the serial key index presented to the ZX-Uno core
//   M2M_NUM_KEYS  number of keys on the MEGA65 keyboard bitmap
//   keyscan_state_e  scan FSM states
//   next_key_idx  round-robin successor of a key index
package keyscan_pkg;

    localparam int unsigned KEY_IDX_W    = 7;
    localparam int unsigned M2M_NUM_KEYS = 80;

    typedef enum logic [1:0] {
        StFlush,
        StScan,
        StHold
    } keyscan_state_e;

    // Successor of idx in a ring of num_keys entries; wraps NUM_KEYS-1 to 0.
    function automatic logic [KEY_IDX_W-1:0] next_key_idx(input logic [KEY_IDX_W-1:0] idx,
                                                          input int unsigned num_keys);
        if (32'(idx) >= num_keys - 32'd1) begin
            return '0;
        end
        return idx + KEY_IDX_W'(1);
    endfunction

endpackage

// File: rtl/keyscan_debounce_cell.sv
// Per-key debounce: a visit-gated disagreement counter plus the reported key bit.
// Ports:
//   clk28mhz         system clock
//   reset_n          asynchronous active-low reset
//   visit            one-cycle strobe: this key is being sampled on this cycle
//   sample_n         synchronized raw key state, 0 = pressed
//   reported_n       debounced key state, 0 = pressed (registered)
//   reported_next_n  value reported_n takes at the next clock edge
module keyscan_debounce_cell #(
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic clk28mhz,
    input  logic reset_n,
    input  logic visit,
    input  logic sample_n,
    output logic reported_n,
    output logic reported_next_n
);

    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d           = cnt_q;
        reported_next_n = reported_n;
        if (visit) begin
            if (sample_n != reported_n) begin
                // Flip only after DEBOUNCE_SCANS consecutive disagreeing visits.
                if (cnt_q + 3'd1 >= 3'(DEBOUNCE_SCANS)) begin
                    reported_next_n = sample_n;
                    cnt_d           = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk28mhz or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            reported_n <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            reported_n <= reported_next_n;
        end
    end

endmodule

// File: rtl/m2m_keyscan_serializer.sv
// Serializes the MEGA65 parallel active-low key bitmap into the key_num / key_status_n
// round-robin scan consumed by the ZX-Uno core (clk28mhz domain).
// Optional per-key debounce across scan passes: define KEYSCAN_DEBOUNCE_EN.
// Ports:
//   clk28mhz      system clock
//   reset_n       asynchronous active-low reset
//   matrix_n      raw key bitmap, 0 = pressed, asynchronous to clk28mhz
//   scan_enable   1 = scan runs, 0 = freeze scan position
//   key_num       index of the key currently presented
//   key_status_n  reported state of key_num, 0 = pressed
//   key_strobe    one-cycle pulse when key_num / key_status_n change
//   scan_wrap     one-cycle pulse when key_num wraps to 0
//   any_key_n     0 when any reported key is pressed
module m2m_keyscan_serializer
    import keyscan_pkg::*;
#(
    parameter int unsigned NUM_KEYS       = M2M_NUM_KEYS,
    parameter int unsigned STEP_CYCLES    = 28,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic                 clk28mhz,
    input  logic                 reset_n,
    input  logic [NUM_KEYS-1:0]  matrix_n,
    input  logic                 scan_enable,
    output logic [KEY_IDX_W-1:0] key_num,
    output logic                 key_status_n,
    output logic                 key_strobe,
    output logic                 scan_wrap,
    output logic                 any_key_n
);

    localparam int unsigned STEP_W = $clog2(STEP_CYCLES);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    if (NUM_KEYS < 2 || NUM_KEYS > 128) begin : g_bad_num_keys
        $error("NUM_KEYS must be in 2..128");
    end
    if (STEP_CYCLES < 2) begin : g_bad_step_cycles
        $error("STEP_CYCLES must be at least 2");
    end
    if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 7) begin : g_bad_debounce_scans
        $error("DEBOUNCE_SCANS must be in 1..7");
    end

    // Two-flop synchronizer for the asynchronous key bitmap.
    logic [NUM_KEYS-1:0] sync1_q, sync_n;

    always_ff @(posedge clk28mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '1;
            sync_n  <= '1;
        end else begin
            sync1_q <= matrix_n;
            sync_n  <= sync1_q;
        end
    end

    keyscan_state_e       state_q;
    logic                 flush_q;
    logic [STEP_W-1:0]    step_q;
    logic                 step;
    logic [KEY_IDX_W-1:0] next_idx;
    logic [NUM_KEYS-1:0]  visit;
    logic [NUM_KEYS-1:0]  reported;
    logic [NUM_KEYS-1:0]  reported_next;

    // key_num doubles as the scan index. A step is taken on the terminal count only while
    // scan_enable is high, so a falling enable on that cycle suppresses the step. HOLD with
    // scan_enable back high already counts, resuming from the frozen value.
    always_comb begin
        next_idx = next_key_idx(key_num, NUM_KEYS);
        step     = (state_q != StFlush) && scan_enable && (step_q == STEP_LAST);
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_visit
        assign visit[k] = step && (next_idx == KEY_IDX_W'(k));
    end

`ifdef KEYSCAN_DEBOUNCE_EN
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_cell
        keyscan_debounce_cell #(
            .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
        ) u_cell (
            .clk28mhz       (clk28mhz),
            .reset_n        (reset_n),
            .visit          (visit[k]),
            .sample_n       (sync_n[k]),
            .reported_n     (reported[k]),
            .reported_next_n(reported_next[k])
        );
    end
`else
    // No filtering: the visited key simply takes its synchronized value.
    assign reported_next = (reported & ~visit) | (sync_n & visit);

    always_ff @(posedge clk28mhz or negedge reset_n) begin
        if (!reset_n) begin
            reported <= '1;
        end else begin
            reported <= reported_next;
        end
    end
`endif

    always_ff @(posedge clk28mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StFlush;
            flush_q      <= 1'b0;
            step_q       <= '0;
            key_num      <= '0;
            key_status_n <= 1'b1;
            key_strobe   <= 1'b0;
            scan_wrap    <= 1'b0;
            any_key_n    <= 1'b1;
        end else begin
            key_strobe <= 1'b0;
            scan_wrap  <= 1'b0;
            any_key_n  <= &reported;
            unique case (state_q)
                StFlush: begin
                    // Two cycles so the synchronizer holds real samples before the first visit.
                    flush_q <= 1'b1;
                    if (flush_q) begin
                        state_q <= scan_enable ? StScan : StHold;
                    end
                end
                StScan, StHold: begin
                    if (!scan_enable) begin
                        state_q <= StHold;
                    end else begin
                        state_q <= StScan;
                        if (step) begin
                            step_q       <= '0;
                            key_num      <= next_idx;
                            // Present the value being written this edge, not the stale one.
                            key_status_n <= reported_next[next_idx];
                            key_strobe   <= 1'b1;
                            scan_wrap    <= (next_idx == '0);
                        end else begin
                            step_q <= step_q + STEP_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= StFlush;
                end
            endcase
        end
    end

endmodule
